// File: rtl/logic_op_scheduler.sv
// logic_op_scheduler: round-robin sharing of one 32-bit AND/OR/NOR/INV unit between two requesters
module logic_op_scheduler #(
  parameter int DATA_W = 32,
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0_VALID,
  output logic               REQ0_READY,
  input  logic [1:0]         REQ0_OP,
  input  logic [DATA_W-1:0]  REQ0_A,
  input  logic [DATA_W-1:0]  REQ0_B,
  input  logic               REQ1_VALID,
  output logic               REQ1_READY,
  input  logic [1:0]         REQ1_OP,
  input  logic [DATA_W-1:0]  REQ1_A,
  input  logic [DATA_W-1:0]  REQ1_B,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic               RES_ID,
  output logic [DATA_W-1:0]  RES_DATA,
  output logic               RES_ZERO,
  output logic [COUNT_W-1:0] OP_COUNT
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic ptr, id_q, acc0, acc1;
  logic [1:0] op_q;
  logic [DATA_W-1:0] a_q, b_q, result;
  always_ff @(posedge CLK) state <= RST ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? ((acc0 | acc1) ? EXEC : IDLE) :
               state == EXEC ? DONE :
               RES_READY ? IDLE : DONE;
  end
  always_comb begin
    REQ0_READY = (state == IDLE) & ~RST & REQ0_VALID & (~REQ1_VALID | ~ptr);
    REQ1_READY = (state == IDLE) & ~RST & REQ1_VALID & (~REQ0_VALID | ptr);
    acc0 = REQ0_VALID & REQ0_READY;
    acc1 = REQ1_VALID & REQ1_READY;
    result = op_q == 2'b00 ? a_q & b_q :
             op_q == 2'b01 ? a_q | b_q :
             op_q == 2'b10 ? ~(a_q | b_q) : ~a_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= 1'b0;
      id_q <= 1'b0;
      op_q <= 2'b00;
      a_q <= '0;
      b_q <= '0;
      RES_VALID <= 1'b0;
      RES_DATA <= '0;
      RES_ID <= 1'b0;
      RES_ZERO <= 1'b0;
      OP_COUNT <= '0;
    end else begin
      if (acc0 | acc1) begin
        op_q <= acc1 ? REQ1_OP : REQ0_OP;
        a_q <= acc1 ? REQ1_A : REQ0_A;
        b_q <= acc1 ? REQ1_B : REQ0_B;
        id_q <= acc1;
        ptr <= ~acc1;
      end
      if (state == EXEC) begin
        RES_DATA <= result;
        RES_ZERO <= result == '0;
        RES_ID <= id_q;
        RES_VALID <= 1'b1;
      end
      if (RES_VALID & RES_READY) begin
        RES_VALID <= 1'b0;
        OP_COUNT <= OP_COUNT + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_logic_op_scheduler.sv
// tb_logic_op_scheduler: directed table-driven bench for logic_op_scheduler
module tb_logic_op_scheduler;
  logic clk, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic res_valid, res_ready, res_id, res_zero;
  logic [31:0] res_data;
  logic [3:0] op_count, exp_cnt;
  int checks, failures;
  typedef struct {
    logic id;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic z;
  } vec_t;
  vec_t vecs[8];
  logic_op_scheduler #(.DATA_W(32), .COUNT_W(4)) dut (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_OP(req0_op), .REQ0_A(req0_a), .REQ0_B(req0_b),
    .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_OP(req1_op), .REQ1_A(req1_a), .REQ1_B(req1_b),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_ID(res_id), .RES_DATA(res_data),
    .RES_ZERO(res_zero), .OP_COUNT(op_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic z);
    int n;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", id ? req1_ready : req0_ready, 1);
    chk("ready_exclusive", req0_ready & req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_no_valid", res_valid, 0);
    tick();
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp);
    chk("res_id", res_id, id);
    chk("res_zero", res_zero, z);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_cnt++;
    chk("consumed_valid", res_valid, 0);
    chk("op_count", op_count, exp_cnt);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0;
    failures = 0;
    exp_cnt = 4'd0;
    vecs[0] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[1] = '{1'b0, 2'b01, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{1'b0, 2'b10, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b1, 2'b11, 32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b1, 2'b00, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'hA5A5_0000, 1'b0};
    vecs[7] = '{1'b0, 2'b01, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0};
    rst = 1'b1;
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_res_data", res_data, 0);
    end
    rst = 1'b0;
    #1;
    chk("first_grant0", req0_ready, 1);
    chk("first_grant1", req1_ready, 0);
    req1_valid = 1'b0;
    req0_valid = 1'b0;
    do_op(1'b0, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0);
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h1234_5678; req1_b = 32'hFFFF_FFFF;
    #1;
    chk("bp_grant1", req1_ready, 1);
    chk("bp_grant0_low", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    chk("bp_exec_valid", res_valid, 0);
    tick();
    chk("bp_valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_data", res_data, 32'hEDCB_A987);
      chk("bp_hold_id", res_id, 1);
      chk("bp_no_ready", req0_ready | req1_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_cnt++;
    chk("bp_consumed", res_valid, 0);
    chk("bp_count", op_count, exp_cnt);
    chk("bp_idle_ready", req0_ready, 1);
    req0_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_00FF; req0_b = 32'h0000_FF00;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hFFFF_0000; req1_b = 32'h0000_FFFF;
    res_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
        tick();
        n++;
      end
      chk("rr_grant0", req0_ready, k % 2 == 0);
      chk("rr_grant1", req1_ready, k % 2 == 1);
      tick();
      chk("rr_exec_valid", res_valid, 0);
      tick();
      chk("rr_valid", res_valid, 1);
      chk("rr_id", res_id, k % 2);
      chk("rr_data", res_data, k % 2 == 1 ? 32'h0000_0000 : 32'h0000_FFFF);
      chk("rr_zero", res_zero, k % 2);
      tick();
      exp_cnt++;
      chk("rr_consumed", res_valid, 0);
      chk("rr_count", op_count, exp_cnt);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].z);
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
    #1;
    chk("mid_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 4'd0;
    chk("mid_res_valid", res_valid, 0);
    chk("mid_op_count", op_count, 0);
    chk("mid_res_data", res_data, 0);
    tick();
    chk("mid_no_pulse", res_valid, 0);
    tick();
    chk("mid_no_pulse2", res_valid, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_ptr0", req0_ready, 1);
    chk("mid_ptr1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      logic [31:0] v;
      v = i;
      do_op(v[0], 2'b01, v, 32'h0, v, 1'b0);
      if (i >= 15) chk("wrap_count", op_count, i == 15 ? 15 : i == 16 ? 0 : 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
